// File: rtl/ahb_slave_mem.sv
// Word-addressed bus slave memory with programmable wait states and two-cycle ERROR responses.
// Optional macro SLAVE_WPROT_EN: writes to the lowest PROT_WORDS words take the ERROR path.
module ahb_slave_mem #(
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 1,
  parameter int PROT_WORDS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic        valid,
  input  logic        read_write,
  input  logic [15:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [1:0]  resp
);

  localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [15:0] DEPTH_LIM = 16'(MEM_DEPTH);
  localparam logic [15:0] PROT_LIM  = 16'(PROT_WORDS);
`ifdef SLAVE_WPROT_EN
  localparam logic        PROT_ON   = 1'b1;
`else
  localparam logic        PROT_ON   = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [31:0]       wdata_reg;
  logic              write_reg;
  logic              ready_reg, ready_next;
  logic [1:0]        resp_reg, resp_next;
  logic [31:0]       rdata_reg;
  logic [31:0]       mem_reg [MEM_DEPTH];

  logic              accept;
  logic              addr_err;
  logic              commit_en;
  logic [IDX_W-1:0]  commit_idx;
  logic [31:0]       commit_wdata;
  logic              commit_write;

  assign accept = hsel && valid && ((state_reg == IDLE) || (state_reg == DONE));

  // Misaligned, beyond the array, or (when enabled) a write into the protected low words.
  assign addr_err = (address[1:0] != 2'b00)
                 || ({2'b00, address[15:2]} >= DEPTH_LIM)
                 || (PROT_ON && read_write && ({2'b00, address[15:2]} < PROT_LIM));

  // With zero wait states the commit happens on the accept edge, so use the live bus.
  always_comb begin
    if (state_reg == WAIT) begin
      commit_idx   = idx_reg;
      commit_wdata = wdata_reg;
      commit_write = write_reg;
    end else begin
      commit_idx   = address[IDX_W+1:2];
      commit_wdata = wdata;
      commit_write = read_write;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit_en  = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (state_reg == DONE) state_next = IDLE;
        if (accept) begin
          if (addr_err) begin
            state_next = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = DONE;
            commit_en  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd0) begin
          state_next = DONE;
          commit_en  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      ERR1:    state_next = ERR2;
      ERR2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    ready_next = 1'b1;
    resp_next  = RESP_OKAY;
    case (state_next)
      WAIT: ready_next = 1'b0;
      ERR1: begin
        ready_next = 1'b0;
        resp_next  = RESP_ERROR;
      end
      ERR2:    resp_next = RESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      ready_reg <= 1'b1;
      resp_reg  <= RESP_OKAY;
      idx_reg   <= '0;
      wdata_reg <= 32'd0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
      resp_reg  <= resp_next;
      if (accept) begin
        idx_reg   <= address[IDX_W+1:2];
        wdata_reg <= wdata;
        write_reg <= read_write;
      end
    end
  end

  // Reset clears the whole array, so a write caught mid-wait is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_reg[i] <= 32'd0;
      rdata_reg <= 32'd0;
    end else if (commit_en) begin
      if (commit_write) mem_reg[commit_idx] <= commit_wdata;
      else              rdata_reg <= mem_reg[commit_idx];
    end
  end

  assign rdata = rdata_reg;
  assign ready = ready_reg;
  assign resp  = resp_reg;

endmodule
